// File: rtl/fixed_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fixed_pkg
//  Description : Shared constants and the controller state type for the
//                fixed-predictor encoder.
//                  SAMPLE_W  - default PCM sample width
//                  RES_W     - default residual width (order-4 worst case)
//                  MAX_ORDER - highest legal predictor order
//                  ACC_W     - width of the optional |residual| accumulators
//  Revision    : 1.0 - initial release
// ============================================================================
package fixed_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int RES_W     = SAMPLE_W + 4;
    localparam int MAX_ORDER = 4;
    localparam int ACC_W     = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } fixedState_e;

endpackage : fixed_pkg
`default_nettype wire

// File: rtl/fixed_residual.sv
`default_nettype none
// ============================================================================
//  Module      : fixed_residual
//  Description : Combinational fixed-predictor residual calculator. Produces
//                the order 0..4 residuals of the current sample against the
//                four previous samples, all at RES_W bits signed.
//  Ports       : iX0          current sample x[n]
//                iX1..iX4     history x[n-1]..x[n-4]
//                oR0..oR4     residuals for orders 0..4
//  Revision    : 1.0 - initial release
// ============================================================================
module fixed_residual #(
    parameter int SAMPLE_W = fixed_pkg::SAMPLE_W,
    parameter int RES_W    = SAMPLE_W + 4
) (
    input  logic signed [SAMPLE_W-1:0] iX0,
    input  logic signed [SAMPLE_W-1:0] iX1,
    input  logic signed [SAMPLE_W-1:0] iX2,
    input  logic signed [SAMPLE_W-1:0] iX3,
    input  logic signed [SAMPLE_W-1:0] iX4,
    output logic signed [RES_W-1:0]    oR0,
    output logic signed [RES_W-1:0]    oR1,
    output logic signed [RES_W-1:0]    oR2,
    output logic signed [RES_W-1:0]    oR3,
    output logic signed [RES_W-1:0]    oR4
);
    import fixed_pkg::*;

    logic signed [RES_W-1:0] wX0, wX1, wX2, wX3, wX4;

    assign wX0 = {{(RES_W-SAMPLE_W){iX0[SAMPLE_W-1]}}, iX0};
    assign wX1 = {{(RES_W-SAMPLE_W){iX1[SAMPLE_W-1]}}, iX1};
    assign wX2 = {{(RES_W-SAMPLE_W){iX2[SAMPLE_W-1]}}, iX2};
    assign wX3 = {{(RES_W-SAMPLE_W){iX3[SAMPLE_W-1]}}, iX3};
    assign wX4 = {{(RES_W-SAMPLE_W){iX4[SAMPLE_W-1]}}, iX4};

    // Binomial coefficients built from shifts and adds so every term stays
    // at RES_W bits; the worst-case magnitude (16 * 2^(SAMPLE_W-1)) fits.
    assign oR0 = wX0;
    assign oR1 = wX0 - wX1;
    assign oR2 = wX0 - (wX1 <<< 1) + wX2;
    assign oR3 = wX0 - ((wX1 <<< 1) + wX1) + ((wX2 <<< 1) + wX2) - wX3;
    assign oR4 = wX0 - (wX1 <<< 2) + ((wX2 <<< 2) + (wX2 <<< 1))
               - (wX3 <<< 2) + wX4;

endmodule : fixed_residual
`default_nettype wire

// File: rtl/fixed_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : fixed_encoder
//  Description : Fixed-predictor (orders 0..4) PCM residual encoder. The
//                order is latched on the first enabled sample after reset;
//                the first N samples are passed through verbatim as warm-up,
//                after which the order-N residual is emitted one cycle after
//                each consumed sample.
//  Ports       : iClock, iReset        clock, async active-high reset
//                iEnable, iOrder,      sample strobe, requested order,
//                iSample               signed PCM sample
//                oData, oValid,        residual / warm-up sample, strobe,
//                oWarmup, oError       warm-up qualifier, sticky bad-order
//  Option      : FIXED_ENCODER_ABSSUM_EN adds oAbsSum0..oAbsSum4 (running
//                sums of |r0|..|r4| from sample index 4 on, RUN phase) and
//                oBestOrder (index of the smallest sum, lowest on ties).
//  Revision    : 1.0 - initial release
// ============================================================================
module fixed_encoder #(
    parameter int SAMPLE_W = fixed_pkg::SAMPLE_W,
    parameter int RES_W    = SAMPLE_W + 4
) (
    input  logic                       iClock,
    input  logic                       iReset,
    input  logic                       iEnable,
    input  logic [7:0]                 iOrder,
    input  logic signed [SAMPLE_W-1:0] iSample,
    output logic signed [RES_W-1:0]    oData,
    output logic                       oValid,
    output logic                       oWarmup,
    output logic                       oError
`ifdef FIXED_ENCODER_ABSSUM_EN
    ,
    output logic [31:0]                oAbsSum0,
    output logic [31:0]                oAbsSum1,
    output logic [31:0]                oAbsSum2,
    output logic [31:0]                oAbsSum3,
    output logic [31:0]                oAbsSum4,
    output logic [2:0]                 oBestOrder
`endif
);
    import fixed_pkg::*;

    fixedState_e              rState;
    logic [2:0]               rOrder;
    logic [2:0]               rWarmCnt;
    logic signed [SAMPLE_W-1:0] rHist [0:3];   // x[n-1] .. x[n-4]

    logic signed [RES_W-1:0]  wR0, wR1, wR2, wR3, wR4;
    logic signed [RES_W-1:0]  wSel;
    logic signed [RES_W-1:0]  wSext;
    logic                     wOrderLegal;

    fixed_residual #(
        .SAMPLE_W (SAMPLE_W),
        .RES_W    (RES_W)
    ) uResidual (
        .iX0 (iSample),
        .iX1 (rHist[0]),
        .iX2 (rHist[1]),
        .iX3 (rHist[2]),
        .iX4 (rHist[3]),
        .oR0 (wR0),
        .oR1 (wR1),
        .oR2 (wR2),
        .oR3 (wR3),
        .oR4 (wR4)
    );

    assign wSext       = {{(RES_W-SAMPLE_W){iSample[SAMPLE_W-1]}}, iSample};
    assign wOrderLegal = (iOrder <= 8'(MAX_ORDER));

    always_comb begin
        wSel = wR0;
        case (rOrder)
            3'd0:    wSel = wR0;
            3'd1:    wSel = wR1;
            3'd2:    wSel = wR2;
            3'd3:    wSel = wR3;
            default: wSel = wR4;
        endcase
    end

    // History advances on every enabled cycle and nowhere else, so idle gaps
    // leave the predictor context untouched.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            for (int i = 0; i < 4; i++) begin
                rHist[i] <= '0;
            end
        end else if (iEnable) begin
            rHist[0] <= iSample;
            rHist[1] <= rHist[0];
            rHist[2] <= rHist[1];
            rHist[3] <= rHist[2];
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            rState   <= IDLE;
            rOrder   <= 3'd0;
            rWarmCnt <= 3'd0;
            oData    <= '0;
            oValid   <= 1'b0;
            oWarmup  <= 1'b0;
            oError   <= 1'b0;
        end else begin
            oValid <= 1'b0;
            if (iEnable) begin
                case (rState)
                    IDLE: begin
                        // Once an illegal order was seen, stay parked here
                        // and swallow every sample until reset.
                        if (!oError) begin
                            if (!wOrderLegal) begin
                                oError <= 1'b1;
                            end else begin
                                rOrder <= iOrder[2:0];
                                oValid <= 1'b1;
                                if (iOrder == 8'd0) begin
                                    rState  <= RUN;
                                    oData   <= wR0;
                                    oWarmup <= 1'b0;
                                end else begin
                                    rWarmCnt <= 3'd1;
                                    oData    <= wSext;
                                    oWarmup  <= 1'b1;
                                    rState   <= (iOrder == 8'd1) ? RUN : WARMUP;
                                end
                            end
                        end
                    end
                    WARMUP: begin
                        oValid   <= 1'b1;
                        oData    <= wSext;
                        oWarmup  <= 1'b1;
                        rWarmCnt <= rWarmCnt + 3'd1;
                        if ((rWarmCnt + 3'd1) == rOrder) begin
                            rState <= RUN;
                        end
                    end
                    RUN: begin
                        oValid  <= 1'b1;
                        oData   <= wSel;
                        oWarmup <= 1'b0;
                    end
                    default: begin
                        rState <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef FIXED_ENCODER_ABSSUM_EN
    logic [2:0]              rSampleCnt;     // samples consumed, saturates at 4
    logic [ACC_W-1:0]        rAbsSum [0:4];
    logic signed [RES_W-1:0] wRes    [0:4];
    logic                    wResidualCycle;
    logic                    wAccumulate;

    assign wRes[0] = wR0;
    assign wRes[1] = wR1;
    assign wRes[2] = wR2;
    assign wRes[3] = wR3;
    assign wRes[4] = wR4;

    // A residual is produced this cycle in RUN, or in IDLE when an order-0
    // stream starts.
    assign wResidualCycle = iEnable &&
                            ((rState == RUN) ||
                             ((rState == IDLE) && !oError && (iOrder == 8'd0)));
    assign wAccumulate    = wResidualCycle && (rSampleCnt == 3'd4);

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            rSampleCnt <= 3'd0;
        end else if (iEnable && !oError && wOrderLegal | (rState != IDLE)) begin
            if (rSampleCnt != 3'd4) begin
                rSampleCnt <= rSampleCnt + 3'd1;
            end
        end
    end

    for (genvar g = 0; g < 5; g++) begin : g_absAcc
        logic signed [RES_W-1:0] wAbs;
        assign wAbs = wRes[g][RES_W-1] ? -wRes[g] : wRes[g];
        always_ff @(posedge iClock or posedge iReset) begin
            if (iReset) begin
                rAbsSum[g] <= '0;
            end else if (wAccumulate) begin
                rAbsSum[g] <= rAbsSum[g] + {{(ACC_W-RES_W){1'b0}}, wAbs};
            end
        end
    end

    assign oAbsSum0 = rAbsSum[0];
    assign oAbsSum1 = rAbsSum[1];
    assign oAbsSum2 = rAbsSum[2];
    assign oAbsSum3 = rAbsSum[3];
    assign oAbsSum4 = rAbsSum[4];

    always_comb begin
        logic [ACC_W-1:0] best;
        best       = rAbsSum[0];
        oBestOrder = 3'd0;
        for (int i = 1; i < 5; i++) begin
            // Strict compare keeps the lowest index on ties.
            if (rAbsSum[i] < best) begin
                best       = rAbsSum[i];
                oBestOrder = 3'(i);
            end
        end
    end
`endif

endmodule : fixed_encoder
`default_nettype wire
